// File: rtl/scan_frame_harness.sv
// rtl/scan_frame_harness.sv - serial-to-parallel ROI harness with handshakes, auto settle/capture, frame counter and flush
module scan_frame_harness #(
    parameter int DIN_N   = 256,
    parameter int DOUT_N  = 256,
    parameter int SETTLE  = 2,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               di,
    input  logic               di_valid,
    output logic               di_ready,
    output logic               do_bit,
    output logic               do_valid,
    input  logic               do_ready,
    input  logic               flush,
    output logic [DIN_N-1:0]   roi_din,
    input  logic [DOUT_N-1:0]  roi_dout,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy
);

    localparam int IW = $clog2(DIN_N);
    localparam int OW = $clog2(DOUT_N);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IW-1:0] IN_LAST     = IW'(DIN_N - 1);
    localparam logic [OW-1:0] OUT_LAST    = OW'(DOUT_N - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SETTLE,
        ST_UNLOAD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIN_N-1:0]   din_shr;
    logic [DOUT_N-1:0]  dout_shr;
    logic [IW-1:0]      in_cnt;
    logic [OW-1:0]      out_cnt;
    logic [SW-1:0]      settle_cnt;

    // The outgoing bit is always the MSB of the unload shifter; it reads 0 after reset.
    assign do_bit = dout_shr[DOUT_N-1];
    assign busy   = (state != ST_LOAD) || (in_cnt != '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        di_ready  = 1'b0;
        do_valid  = 1'b0;
        case (state)
            ST_LOAD: begin
                di_ready = !rst;
                if (di_valid && !rst && (in_cnt == IN_LAST)) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                do_valid = 1'b1;
                if (do_ready && (out_cnt == OUT_LAST)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
        if (flush) begin
            state_nxt = ST_LOAD;
        end
    end

    // Datapath: shift in, load roi_din on the last bit, capture after settling, shift out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_shr    <= '0;
            dout_shr   <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            settle_cnt <= '0;
            roi_din    <= '0;
            frame_cnt  <= '0;
        end else if (flush) begin
            // roi_din, frame_cnt and dout_shr are deliberately left alone.
            din_shr    <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (di_valid) begin
                        din_shr <= {din_shr[DIN_N-2:0], di};
                        if (in_cnt == IN_LAST) begin
                            roi_din    <= {din_shr[DIN_N-2:0], di};
                            in_cnt     <= '0;
                            settle_cnt <= '0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        dout_shr  <= roi_dout;
                        frame_cnt <= frame_cnt + 1'b1;
                        out_cnt   <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (do_ready) begin
                        dout_shr <= {dout_shr[DOUT_N-2:0], 1'b0};
                        if (out_cnt == OUT_LAST) begin
                            out_cnt <= '0;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    in_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/scan_frame_harness.md
Name: scan_frame_harness

Overview:
- Parametrised serial-to-parallel harness that feeds a wide ROI input bus from a 1-bit input stream and returns a wide ROI output bus as a 1-bit output stream.
- Successor to the fixed 256/256 strobe-driven shift harness. Adds:
  - independent DIN_N and DOUT_N widths;
  - valid/ready handshakes on both serial sides;
  - automatic apply/settle/capture sequencing, so no external strobe is needed;
  - a frame counter and a flush control.
- Sits between the top-level pins and the roi instance in fuzzer/minitest tops.

Parameters:
- DIN_N, 256, width of roi_din (bits shifted in per frame), >=2
- DOUT_N, 256, width of roi_dout (bits shifted out per frame), >=2
- SETTLE, 2, cycles roi_din is held stable before roi_dout is sampled, >=1
- FRAME_W, 8, width of the frame counter

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- di  in  1  serial input bit
- di_valid  in  1  di carries a bit this cycle
- di_ready  out  1  harness accepts di this cycle
- do  out  1  serial output bit
- do_valid  out  1  do carries a bit this cycle
- do_ready  in  1  consumer accepts do this cycle
- flush  in  1  synchronous abort of the current frame
- roi_din  out  DIN_N  parallel stimulus to the ROI
- roi_dout  in  DOUT_N  parallel response from the ROI
- frame_cnt  out  FRAME_W  number of completed captures, wraps
- busy  out  1  frame in progress

Behaviour:
- Reset (async assert, sync release): state=LOAD, din_shr=0, dout_shr=0, in_cnt=0, out_cnt=0, settle_cnt=0, roi_din=0, frame_cnt=0, do=0, do_valid=0. di_ready=0 while rst is high.
- State LOAD:
  - di_ready=1 (combinational on state and !rst).
  - Input transfer when di_valid && di_ready: din_shr <= {din_shr[DIN_N-2:0], di}; in_cnt++.
  - di_valid=0 leaves everything unchanged.
- Frame load: on the transfer where in_cnt==DIN_N-1, roi_din <= {din_shr[DIN_N-2:0], di} on that same edge, in_cnt<=0, settle_cnt<=0, state->SETTLE.
- Bit order: the first bit received lands in roi_din[DIN_N-1].
- Between frames: roi_din changes only at a frame load; it holds its value otherwise, including through flush.
- State SETTLE:
  - di_ready=0.
  - Each edge: if settle_cnt==SETTLE-1, then dout_shr<=roi_dout, frame_cnt++ (wraps modulo 2^FRAME_W), out_cnt<=0, state->UNLOAD. Otherwise settle_cnt++.
  - roi_dout is therefore sampled exactly SETTLE edges after the roi_din update.
- State UNLOAD:
  - do_valid=1, do=dout_shr[DOUT_N-1], di_ready=0.
  - Output transfer when do_valid && do_ready: dout_shr <= {dout_shr[DOUT_N-2:0], 1'b0}; out_cnt++.
  - On the transfer where out_cnt==DOUT_N-1: state->LOAD, do_valid<=0.
  - do_ready=0 holds do and do_valid stable (no bit lost or duplicated).
  - First bit out is roi_dout[DOUT_N-1].
- Latency:
  - do_valid rises SETTLE edges after the edge that accepted the last input bit.
  - Minimum frame period is DIN_N+SETTLE+DOUT_N cycles.
- busy = (state!=LOAD) || (in_cnt!=0).
- flush:
  - Priority over all transfers; only rst overrides it.
  - Next edge: state->LOAD, in_cnt=0, out_cnt=0, settle_cnt=0, do_valid=0, din_shr=0.
  - Preserved: roi_din and frame_cnt.
  - flush during SETTLE skips the capture, and frame_cnt is not incremented.
  - flush on the same edge as a final-bit transfer wins: roi_din is not updated.
- Ignored inputs: di_valid outside LOAD and do_ready outside UNLOAD have no effect.
- Reset mid-frame: immediate return to reset values, including roi_din=0.
- Counters: in_cnt and out_cnt are sized to hold DIN_N-1 and DOUT_N-1 respectively. Arithmetic is unsigned, with no overflow inside the valid range.

Test Plan:
- Reset: DIN_N=8, DOUT_N=8, SETTLE=2, hold rst -> roi_din=0x00, do_valid=0, di_ready=0, frame_cnt=0, busy=0. Release rst -> di_ready=1 next cycle.
- Load and loopback: shift 1,0,1,0,0,1,0,1 with di_valid=1, roi_dout tied to ~roi_din.
  - roi_din=0xA5 after the 8th accepting edge.
  - do_valid=1 two edges later.
  - With do_ready=1, do streams 0,1,0,1,1,0,1,0 (0x5A MSB first).
  - frame_cnt=1; di_ready=1 after the 8th output bit.
- Backpressure: during UNLOAD toggle do_ready 1,0,0,1,... -> each bit held while do_ready=0. Exactly 8 bits delivered, matching 0x5A; no repeats.
- Gapped input: di_valid pattern 1,0,1,1,0,... carrying 0x3C -> roi_din=0x3C only after the 8th valid bit; bits presented with di_valid=0 are ignored.
- Flush:
  - Flush after 5 input bits -> in_cnt=0, busy=0, roi_din keeps its previous 0xA5.
  - Flush in SETTLE -> frame_cnt unchanged, no do_valid.
  - Flush mid-UNLOAD after 3 bits -> do_valid=0 next cycle.
- Wrap and async reset: FRAME_W=2, run 5 full frames -> frame_cnt sequence 1,2,3,0,1. Then assert rst asynchronously mid-UNLOAD -> do_valid=0 and roi_din=0 before the next clk edge.
